mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares the single external memory port (QSPI flash/RAM controller, start/done handshake) between
// two requesters: the instruction-fetch path (CU PC -> IR/operand bytes) and the data path (load/store).
// It sits between the control unit / datapath and the memory controller.
// It serialises one transaction at a time, registers the winner's command and returns read data with a 1-cycle ack.
// PARAMETERS
// ADDR_W        23  address width, matches PC width
// DATA_W        8   data byte width
// MAX_DATA_RUN  4   max consecutive data grants while fetch is pending before fetch is forced (>=1)
// PORTS
// clk         in   1       clock
// rst         in   1       reset, asynchronous, active-high
// f_req       in   1       fetch request; hold high with f_addr stable until f_ack
// f_addr      in   ADDR_W  fetch address
// f_ack       out  1       1-cycle pulse: fetch done, f_rdata valid this cycle
// f_rdata     out  DATA_W  fetch read data, held until next fetch ack
// d_req       in   1       data request; hold high with d_we/d_addr/d_wdata stable until d_ack
// d_we        in   1       1 = write, 0 = read
// d_addr      in   ADDR_W  data address
// d_wdata     in   DATA_W  write data
// d_ack       out  1       1-cycle pulse: data transaction done, d_rdata valid if read
// d_rdata     out  DATA_W  data read data, held until next data read ack
// mem_start   out  1       1-cycle pulse to memory controller: command valid
// mem_we      out  1       registered command: write enable
// mem_addr    out  ADDR_W  registered command: address
// mem_wdata   out  DATA_W  registered command: write data
// mem_rdata   in   DATA_W  memory read data, valid with mem_done
// mem_done    in   1       1-cycle pulse from memory controller: command complete
// busy        out  1       high in any state other than IDLE
// owner       out  1       current/last grant: 0 = fetch, 1 = data
// BEHAVIOUR
// - Reset (async): state=IDLE. f_ack, d_ack, mem_start, mem_we, busy = 0.
//   f_rdata, d_rdata, mem_addr, mem_wdata = 0. owner = 0. data_run counter = 0.
// - FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. All outputs are registered or pure decodes of state.
// - IDLE: f_req and d_req are sampled each cycle. If either is high, the winner is chosen and its
//   command (we, addr, wdata) is latched into mem_* and owner. Next state is ISSUE.
//   Fetch commands latch mem_we=0 and mem_wdata=0.
// - Arbitration when both requests are high:
//   - Data wins unless data_run == MAX_DATA_RUN; in that case fetch wins.
//   - data_run increments on each data grant made while f_req is high (saturates at MAX_DATA_RUN).
//   - data_run clears on any fetch grant, and on any data grant while f_req is low.
//   - Only one request high: that requester wins.
// - ISSUE: mem_start=1 for exactly this cycle. Next state is WAIT unconditionally.
//   mem_done in ISSUE is ignored; the memory controller guarantees done >= 1 cycle after start.
// - WAIT: mem_* is held stable. On mem_done, mem_rdata is captured into the owner's rdata register,
//   but only for fetch or data-read transactions; d_rdata is unchanged on writes. Next state is ACK.
//   With no mem_done the FSM stays in WAIT indefinitely; there is no timeout.
// - ACK: the owner's ack is high for this one cycle only. Next state is IDLE.
//   The requester drops req on the clock edge that ends the ack cycle.
//   A req still high in IDLE is treated as a new transaction.
// - Latency: req high at edge 0 in IDLE -> mem_start in cycle 1 -> mem_done in cycle k (k>=2)
//   -> ack in cycle k+1. Minimum req-to-ack latency is 3 cycles.
// - Request withdrawn mid-transaction: the transaction still completes and ack still pulses
//   (protocol violation, not detected). The other requester waits; it is never granted mid-flight.
// - Reset mid-transaction: returns to IDLE immediately with outputs at reset values.
//   No ack is issued. The memory controller shares rst and aborts too.
// - Never more than one ack high per cycle. Never a second mem_start before the prior mem_done.
// TESTING
// - Reset: assert rst in WAIT with mem_done pending -> next cycle busy=0, mem_start=0; no f_ack/d_ack ever.
// - Single fetch: f_req=1, f_addr=0x00_0010; mem_done 3 cycles after mem_start with rdata=0xA5
//   -> mem_addr=0x10, mem_we=0, one mem_start; f_ack 1 cycle after done; f_rdata=0xA5.
// - Data write: d_req=1, d_we=1, d_addr=0x40_0000, d_wdata=0x3C -> mem_we=1, mem_wdata=0x3C;
//   d_ack pulses; d_rdata unchanged.
// - Simultaneous: f_req and d_req both raised in the same cycle -> data served first (owner=1),
//   then fetch (owner=0); acks in that order, never overlapping.
// - Starvation with MAX_DATA_RUN=2: d_req re-raised after every ack while f_req stays high
//   -> grant order is D, D, F, D, D, F...
// - Minimum latency: mem_done in the first WAIT cycle -> ack exactly 3 cycles after req sampled;
//   mem_done pulses in ISSUE are ignored.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory controller.
// The slave modport is the arbiter's view; the master modport is the requester/controller view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 8
);
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              busy;
  logic              owner;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    output f_ack, f_rdata, d_ack, d_rdata, mem_start, mem_we, mem_addr, mem_wdata,
           busy, owner
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
    input  f_ack, f_rdata, d_ack, d_rdata, mem_start, mem_we, mem_addr, mem_wdata,
           busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one start/done memory port.
// Data normally wins, but fetch is forced after MAX_DATA_RUN back-to-back data grants.
module mem_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int DATA_W       = 8,
  parameter int MAX_DATA_RUN = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_f_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [RUN_W-1:0]  r_data_run;

  logic w_any_req;
  logic w_run_full;
  logic w_grant_data;

  assign w_any_req    = bus.f_req | bus.d_req;
  assign w_run_full   = (r_data_run == RUN_W'(MAX_DATA_RUN));
  assign w_grant_data = bus.d_req & (~bus.f_req | ~w_run_full);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first, so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)    w_next = S_ISSUE;
      S_ISSUE:                   w_next = S_WAIT;
      S_WAIT:  if (bus.mem_done) w_next = S_ACK;
      S_ACK:                     w_next = S_IDLE;
      default:                   w_next = S_IDLE;
    endcase
  end

  // Command latch, starvation counter and read-data capture.
  // NOTE: these are plain registers, not a memory array, so all of them take the async reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_f_rdata   <= '0;
      r_d_rdata   <= '0;
      r_data_run  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_owner <= w_grant_data;
        if (w_grant_data) begin
          r_mem_we    <= bus.d_we;
          r_mem_addr  <= bus.d_addr;
          r_mem_wdata <= bus.d_wdata;
          // Only data grants that pass over a waiting fetch count toward the run.
          if (!bus.f_req)      r_data_run <= '0;
          else if (!w_run_full) r_data_run <= r_data_run + 1'b1;
        end else begin
          r_mem_we    <= 1'b0;
          r_mem_addr  <= bus.f_addr;
          r_mem_wdata <= '0;
          r_data_run  <= '0;
        end
      end
      if (r_state == S_WAIT && bus.mem_done) begin
        if (!r_owner)       r_f_rdata <= bus.mem_rdata;
        else if (!r_mem_we) r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    bus.mem_start = 1'b0;
    bus.busy      = 1'b0;
    bus.f_ack     = 1'b0;
    bus.d_ack     = 1'b0;
    bus.mem_start = (r_state == S_ISSUE);
    bus.busy      = (r_state != S_IDLE);
    bus.f_ack     = (r_state == S_ACK) & ~r_owner;
    bus.d_ack     = (r_state == S_ACK) &  r_owner;
  end

  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.f_rdata   = r_f_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised bench for mem_arbiter; the bench plays both requesters
// and the memory controller, and predicts grants from the arbitration rules.
module tb_mem_arbiter;

  localparam int ADDR_W  = 23;
  localparam int DATA_W  = 8;
  localparam int MAX_RUN = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MAX_DATA_RUN(MAX_RUN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state: consecutive data grants over a waiting fetch, and the read-data holds.
  int          run_model;
  logic [7:0]  exp_f_rdata;
  logic [7:0]  exp_d_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Two acks in one cycle is never legal, whatever the stimulus.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (!(bus.f_ack === 1'b1 && bus.d_ack === 1'b1)) else begin
        failures++;
        $error("FAIL dual_ack: observed f_ack=%b d_ack=%b expected at most one", bus.f_ack, bus.d_ack);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  task automatic raise_fetch(input logic [ADDR_W-1:0] a);
    bus.f_req  = 1'b1;
    bus.f_addr = a;
  endtask

  task automatic raise_data(input logic we, input logic [ADDR_W-1:0] a, input logic [7:0] wd);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
  endtask

  // Run one transaction from the currently raised requests. Called at a negedge.
  // wait_cyc: WAIT cycles before mem_done; junk_issue: pulse mem_done in ISSUE too.
  task automatic do_txn(input int wait_cyc, input bit junk_issue, input logic [7:0] rd,
                        output bit owner_o, output int lat);
    bit                exp_data;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [7:0]        exp_wd;
    bit                seen;
    int                n;

    exp_data = bus.d_req && (!bus.f_req || run_model != MAX_RUN);
    if (exp_data) begin
      exp_we   = bus.d_we;
      exp_addr = bus.d_addr;
      exp_wd   = bus.d_wdata;
      run_model = bus.f_req ? ((run_model < MAX_RUN) ? run_model + 1 : MAX_RUN) : 0;
    end else begin
      exp_we    = 1'b0;
      exp_addr  = bus.f_addr;
      exp_wd    = 8'h00;
      run_model = 0;
    end
    owner_o = exp_data;
    lat     = 0;

    seen = 1'b0;
    n    = 0;
    while (!seen && n < 4) begin
      @(negedge clk);
      n++;
      seen = bus.mem_start;
    end
    check("mem_start_seen", 32'(seen), 1);
    if (!seen) return;
    check("owner",     32'(bus.owner),     32'(exp_data));
    check("mem_we",    32'(bus.mem_we),    32'(exp_we));
    check("mem_addr",  32'(bus.mem_addr),  32'(exp_addr));
    check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_wd));
    check("busy",      32'(bus.busy),      1);

    if (junk_issue) begin
      bus.mem_done  = 1'b1;
      bus.mem_rdata = ~rd;
    end
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("start_pulse_end", 32'(bus.mem_start), 0);
    for (int i = 0; i < wait_cyc; i++) begin
      check("no_early_ack", 32'({bus.f_ack, bus.d_ack}), 0);
      check("addr_held",    32'(bus.mem_addr), 32'(exp_addr));
      @(negedge clk);
    end
    bus.mem_done  = 1'b1;
    bus.mem_rdata = rd;
    @(negedge clk);
    bus.mem_done = 1'b0;
    lat = n + 1 + wait_cyc + 1;

    if (!exp_data)   exp_f_rdata = rd;
    else if (!exp_we) exp_d_rdata = rd;
    check("f_ack",   32'(bus.f_ack),   32'(!exp_data));
    check("d_ack",   32'(bus.d_ack),   32'(exp_data));
    check("f_rdata", 32'(bus.f_rdata), 32'(exp_f_rdata));
    check("d_rdata", 32'(bus.d_rdata), 32'(exp_d_rdata));

    if (exp_data) bus.d_req = 1'b0;
    else          bus.f_req = 1'b0;
  endtask

  initial begin
    bit         own;
    int         lat;
    bit         pattern [6];
    int         starts;

    bus.f_req = 0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 0;
    run_model = 0; exp_f_rdata = 8'h00; exp_d_rdata = 8'h00;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_mem_start", 32'(bus.mem_start), 0);
    check("rst_acks",      32'({bus.f_ack, bus.d_ack}), 0);
    check("rst_owner",     32'(bus.owner), 0);
    check("rst_mem_we",    32'(bus.mem_we), 0);
    check("rst_mem_addr",  32'(bus.mem_addr), 0);
    check("rst_rdata",     32'({bus.f_rdata, bus.d_rdata}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, done three cycles after start.
    raise_fetch(23'h00_0010);
    do_txn(2, 1'b0, 8'hA5, own, lat);
    check("fetch_rdata_A5", 32'(bus.f_rdata), 32'h A5);
    check("fetch_mem_addr", 32'(bus.mem_addr), 32'h10);
    @(negedge clk);
    check("fetch_idle", 32'(bus.busy), 0);

    // Data write leaves d_rdata untouched.
    raise_data(1'b1, 23'h40_0000, 8'h3C);
    do_txn(1, 1'b0, 8'h99, own, lat);
    check("write_wdata", 32'(bus.mem_wdata), 32'h3C);
    check("write_we",    32'(bus.mem_we), 1);
    check("write_d_rdata_kept", 32'(bus.d_rdata), 0);
    @(negedge clk);

    // Minimum latency with a stray done in ISSUE.
    raise_data(1'b0, 23'h12_3456, 8'h00);
    do_txn(0, 1'b1, 8'h5A, own, lat);
    check("min_latency", 32'(lat), 3);
    check("min_lat_d_rdata", 32'(bus.d_rdata), 32'h5A);
    @(negedge clk);

    // Reset while WAIT has a done pending: no ack, outputs back to reset values.
    raise_fetch(23'h00_0777);
    repeat (2) @(negedge clk);
    check("rst_mid_in_wait", 32'(bus.busy), 1);
    bus.mem_done = 1'b1; bus.mem_rdata = 8'h77;
    rst = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b0;
    check("rst_mid_busy",  32'(bus.busy), 0);
    check("rst_mid_start", 32'(bus.mem_start), 0);
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_ack", 32'({bus.f_ack, bus.d_ack}), 0);
      @(negedge clk);
    end
    check("rst_mid_f_rdata", 32'(bus.f_rdata), 0);
    bus.f_req = 1'b0;
    rst = 1'b0;
    run_model = 0; exp_f_rdata = 8'h00; exp_d_rdata = 8'h00;
    @(negedge clk);
    check("rst_mid_no_ack_after", 32'({bus.f_ack, bus.d_ack, bus.busy}), 0);

    // Simultaneous requests: data first, then fetch.
    raise_fetch(23'h00_0020);
    raise_data(1'b0, 23'h40_0004, 8'h00);
    do_txn(1, 1'b0, 8'h11, own, lat);
    check("simul_first_data", 32'(own), 1);
    do_txn(1, 1'b0, 8'h22, own, lat);
    check("simul_second_fetch", 32'(own), 0);
    check("simul_owner_out", 32'(bus.owner), 0);
    @(negedge clk);

    // Starvation bound: D, D, F, D, D, F with both requesters always pending.
    pattern = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    raise_fetch(23'h00_0100);
    raise_data(1'b0, 23'h40_0100, 8'h00);
    for (int i = 0; i < 6; i++) begin
      do_txn(i % 2, 1'b0, 8'(8'h30 + i), own, lat);
      check($sformatf("starve_grant%0d", i), 32'(own), 32'(pattern[i]));
      if (own) raise_data(1'b0, 23'(23'h40_0100 + i), 8'h00);
      else     raise_fetch(23'(23'h00_0100 + i));
    end
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    run_model = 0;

    // Randomised traffic against the reference rules.
    starts = 0;
    for (int t = 0; t < 40; t++) begin
      if (!bus.f_req && $urandom_range(0, 1) == 1) raise_fetch(23'($urandom));
      if (!bus.d_req && $urandom_range(0, 1) == 1)
        raise_data(1'($urandom), 23'($urandom), 8'($urandom));
      if (!bus.f_req && !bus.d_req) raise_fetch(23'($urandom));
      do_txn(int'($urandom_range(0, 3)), 1'($urandom), 8'($urandom), own, lat);
      starts++;
    end
    check("random_txn_count", 32'(starts), 40);
    bus.f_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) @(negedge clk);
    check("final_idle", 32'({bus.busy, bus.mem_start, bus.f_ack, bus.d_ack}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
